mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port 4 KiB byte memory (12-bit address, 8-bit data, synchronous write, registered read) between two requesters, e.g. instruction fetch and load/store. The block accepts at most one access per cycle, registers the winning access onto the memory port, and routes read data back to the issuing port with a fixed latency. A burst cap on consecutive grants keeps one requester from starving the other.

---
 rtl/mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-port byte memory between two requesters (port 0 / port 1).
// At most one access is accepted per cycle. The winning access is registered
// onto the memory port, and read data is routed back to the issuing port two
// cycles after the accept edge. A burst cap bounds consecutive grants to the
// current owner while the other port is waiting, so neither side starves.
//
// Handshake (both ports): pN_req is a valid and pN_gnt is a combinational
// ready. An access transfers at the rising edge where pN_req & pN_gnt. The
// requester holds pN_req and all fields stable until that edge. It may drop
// pN_req without a grant, and that has no effect. Reads complete with a
// one-cycle pN_rvalid pulse. Writes produce no response.
module mem_arbiter #(
   parameter int MAX_BURST = 4,
   parameter int ADDR_W    = 12,
   parameter int DATA_W    = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   // port 0
   input  logic                           p0_req,
   input  logic                           p0_we,
   input  logic [ADDR_W-1:0]              p0_addr,
   input  logic [DATA_W-1:0]              p0_wdata,
   output logic                           p0_gnt,
   output logic                           p0_rvalid,
   output logic [DATA_W-1:0]              p0_rdata,
   // port 1
   input  logic                           p1_req,
   input  logic                           p1_we,
   input  logic [ADDR_W-1:0]              p1_addr,
   input  logic [DATA_W-1:0]              p1_wdata,
   output logic                           p1_gnt,
   output logic                           p1_rvalid,
   output logic [DATA_W-1:0]              p1_rdata,
   // memory port
   output logic                           mem_we,
   output logic [ADDR_W-1:0]              mem_addr,
   output logic [DATA_W-1:0]              mem_wdata,
   input  logic [DATA_W-1:0]              mem_rdata,
   // arbitration state, exposed for checkers
   output logic                           dbg_owner,
   output logic [$clog2(MAX_BURST+1)-1:0] dbg_burst_cnt
);

   localparam int               CNT_W   = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
   localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

   // arbitration state
   logic             owner;
   logic             owner_nxt;
   logic             other;
   logic [CNT_W-1:0] burst_cnt;
   logic [CNT_W-1:0] burst_nxt;

   // request / grant vectors, index = port number
   logic [1:0]       req;
   logic [1:0]       gnt;
   logic             accept;
   logic             acc_port;

   // fields of the winning access
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   // read-return pipeline: s1 follows the accept edge, s2 follows the memory sample edge
   logic             s1_valid;
   logic             s1_port;
   logic             s2_valid;
   logic             s2_port;

   assign req   = {p1_req, p0_req};
   assign other = ~owner;

   // State register: current owner and its count of consecutive accepts
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner     <= 1'b0;
         burst_cnt <= '0;
      end else begin
         owner     <= owner_nxt;
         burst_cnt <= burst_nxt;
      end
   end

   // Next state: the owner keeps counting (saturating), a handover restarts at 1,
   // and an idle cycle clears the count so the owner gets a fresh burst
   always_comb begin
      owner_nxt = owner;
      burst_nxt = '0;
      if (accept) begin
         if (acc_port == owner) begin
            burst_nxt = (burst_cnt >= MAX_CNT) ? MAX_CNT : burst_cnt + ONE_CNT;
         end else begin
            owner_nxt = acc_port;
            burst_nxt = ONE_CNT;
         end
      end
   end

   // Grant: the owner wins unless it has used its burst while the other port waits.
   // No grants are driven while reset is asserted.
   always_comb begin
      gnt = 2'b00;
      if (rst_n) begin
         if (req[owner] && (!req[other] || (burst_cnt < MAX_CNT))) begin
            gnt[owner] = 1'b1;
         end else if (req[other]) begin
            gnt[other] = 1'b1;
         end
      end
   end

   assign p0_gnt   = gnt[0];
   assign p1_gnt   = gnt[1];
   assign accept   = |(req & gnt);
   assign acc_port = gnt[1];

   assign sel_we    = acc_port ? p1_we    : p0_we;
   assign sel_addr  = acc_port ? p1_addr  : p0_addr;
   assign sel_wdata = acc_port ? p1_wdata : p0_wdata;

   // Memory port register: load the winner's fields on accept. Otherwise the
   // address and data hold and the write enable drops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else if (accept) begin
         mem_we    <= sel_we;
         mem_addr  <= sel_addr;
         mem_wdata <= sel_wdata;
      end else begin
         mem_we    <= 1'b0;
      end
   end

   // Read tag pipeline: track which port issued each read, so data returns in
   // accept order and in-flight reads are dropped on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_port  <= 1'b0;
         s2_valid <= 1'b0;
         s2_port  <= 1'b0;
      end else begin
         s1_valid <= accept & ~sel_we;
         s1_port  <= acc_port;
         s2_valid <= s1_valid;
         s2_port  <= s1_port;
      end
   end

   assign p0_rvalid = s2_valid & ~s2_port;
   assign p1_rvalid = s2_valid &  s2_port;
   assign p0_rdata  = p0_rvalid ? mem_rdata : '0;
   assign p1_rdata  = p1_rvalid ? mem_rdata : '0;

   assign dbg_owner     = owner;
   assign dbg_burst_cnt = burst_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a main instance (MAX_BURST=4) and a second
// instance (MAX_BURST=1), each in front of its own behavioural memory.
module tb_mem_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT signals ----------------
  logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
  logic [11:0] p0_addr = '0, p1_addr = '0;
  logic [7:0]  p0_wdata = '0, p1_wdata = '0;
  logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [7:0]  p0_rdata, p1_rdata;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        dbg_owner;
  logic [2:0]  dbg_burst_cnt;

  // ---------------- alternate DUT signals (MAX_BURST=1) ----------------
  logic        a0_req = 1'b0, a1_req = 1'b0;
  logic [11:0] a0_addr = '0, a1_addr = '0;
  logic        a0_gnt, a0_rvalid, a1_gnt, a1_rvalid;
  logic [7:0]  a0_rdata, a1_rdata;
  logic        a_mem_we;
  logic [11:0] a_mem_addr;
  logic [7:0]  a_mem_wdata;
  logic [7:0]  a_mem_rdata;
  logic        a_dbg_owner;
  logic [0:0]  a_dbg_burst_cnt;

  mem_arbiter #(.MAX_BURST(4), .ADDR_W(12), .DATA_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_owner(dbg_owner), .dbg_burst_cnt(dbg_burst_cnt)
  );

  mem_arbiter #(.MAX_BURST(1), .ADDR_W(12), .DATA_W(8)) u_alt (
    .clk(clk), .rst_n(rst_n),
    .p0_req(a0_req), .p0_we(1'b0), .p0_addr(a0_addr), .p0_wdata(8'h00),
    .p0_gnt(a0_gnt), .p0_rvalid(a0_rvalid), .p0_rdata(a0_rdata),
    .p1_req(a1_req), .p1_we(1'b0), .p1_addr(a1_addr), .p1_wdata(8'h00),
    .p1_gnt(a1_gnt), .p1_rvalid(a1_rvalid), .p1_rdata(a1_rdata),
    .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
    .dbg_owner(a_dbg_owner), .dbg_burst_cnt(a_dbg_burst_cnt)
  );

  // ---------------- memory models: sync write, registered read (old data) ----------------
  logic       preload = 1'b1;
  logic [7:0] mem   [0:4095];
  logic [7:0] a_mem [0:4095];

  always @(posedge clk) begin
    if (preload) begin
      mem[12'h005] <= 8'hA5;
      mem[12'h010] <= 8'h3C;
      mem[12'h810] <= 8'h96;
      mem[12'h7FF] <= 8'h11;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
  end

  always @(posedge clk) begin
    if (preload) begin
      a_mem[12'h005] <= 8'hA5;
      a_mem[12'h7FF] <= 8'h5A;
    end else if (a_mem_we) begin
      a_mem[a_mem_addr] <= a_mem_wdata;
    end
    a_mem_rdata <= a_mem[a_mem_addr];
  end

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // scoreboard of expected {p1_rvalid, p0_rvalid, p1_rdata, p0_rdata}, one entry per cycle
  logic [17:0] exp_q[$];

  task automatic sb_cycle(input string name, input logic [17:0] push_val);
    logic [17:0] e;
    e = exp_q.pop_front();
    chk(name, {14'd0, p1_rvalid, p0_rvalid, p1_rdata, p0_rdata}, {14'd0, e});
    exp_q.push_back(push_val);
  endtask

  // ---------------- driver tasks ----------------
  // Apply one cycle of inputs at the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic r0, input logic w0, input logic [11:0] a0, input logic [7:0] d0,
                       input logic r1, input logic w1, input logic [11:0] a1, input logic [7:0] d1);
    @(negedge clk);
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 12'h000, 8'h00);
  endtask

  // Reset with requests held high: no grant may escape and all outputs must read 0.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    p0_req = 1'b1; p1_req = 1'b1; a0_req = 1'b0; a1_req = 1'b0;
    #1;
    chk("rst_gnt",    {30'd0, p1_gnt, p0_gnt}, 32'd0);
    chk("rst_rvalid", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
    chk("rst_rdata",  {16'd0, p1_rdata, p0_rdata}, 32'd0);
    chk("rst_mem",    {11'd0, mem_we, mem_addr, mem_wdata}, 32'd0);
    chk("rst_state",  {28'd0, dbg_owner, dbg_burst_cnt}, 32'd0);
    @(negedge clk);
    p0_req = 1'b0; p1_req = 1'b0;
    rst_n = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        r0, w0;
    logic [11:0] a0;
    logic [7:0]  d0;
    logic        r1, w1;
    logic [11:0] a1;
    logic [7:0]  d1;
    logic [1:0]  gnt;     // {p1, p0}
    logic [1:0]  rvalid;  // {p1, p0}
    logic [7:0]  rd0, rd1;
    logic        mwe;
    logic [11:0] maddr;
    logic [7:0]  mwd;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [11:0] ord;
    logic        port;
    logic [1:0]  exp_g;

    // single read of 0x005, then p1 write 0xC3 to 0x7FF followed by a read back
    vecs[0] = '{1'b1,1'b0,12'h005,8'h00, 1'b0,1'b0,12'h000,8'h00, 2'b01,2'b00,8'h00,8'h00, 1'b0,12'h000,8'h00};
    vecs[1] = '{1'b0,1'b0,12'h000,8'h00, 1'b0,1'b0,12'h000,8'h00, 2'b00,2'b00,8'h00,8'h00, 1'b0,12'h005,8'h00};
    vecs[2] = '{1'b0,1'b0,12'h000,8'h00, 1'b0,1'b0,12'h000,8'h00, 2'b00,2'b01,8'hA5,8'h00, 1'b0,12'h005,8'h00};
    vecs[3] = '{1'b0,1'b0,12'h000,8'h00, 1'b1,1'b1,12'h7FF,8'hC3, 2'b10,2'b00,8'h00,8'h00, 1'b0,12'h005,8'h00};
    vecs[4] = '{1'b0,1'b0,12'h000,8'h00, 1'b1,1'b0,12'h7FF,8'h00, 2'b10,2'b00,8'h00,8'h00, 1'b1,12'h7FF,8'hC3};
    vecs[5] = '{1'b0,1'b0,12'h000,8'h00, 1'b0,1'b0,12'h000,8'h00, 2'b00,2'b00,8'h00,8'h00, 1'b0,12'h7FF,8'h00};
    vecs[6] = '{1'b0,1'b0,12'h000,8'h00, 1'b0,1'b0,12'h000,8'h00, 2'b00,2'b10,8'h00,8'hC3, 1'b0,12'h7FF,8'h00};
    vecs[7] = '{1'b0,1'b0,12'h000,8'h00, 1'b0,1'b0,12'h000,8'h00, 2'b00,2'b00,8'h00,8'h00, 1'b0,12'h7FF,8'h00};

    do_reset();
    preload = 1'b0;

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
            vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
      chk($sformatf("v%0d_gnt", i),    {30'd0, p1_gnt, p0_gnt}, {30'd0, vecs[i].gnt});
      chk($sformatf("v%0d_rvalid", i), {30'd0, p1_rvalid, p0_rvalid}, {30'd0, vecs[i].rvalid});
      chk($sformatf("v%0d_rdata0", i), {24'd0, p0_rdata}, {24'd0, vecs[i].rd0});
      chk($sformatf("v%0d_rdata1", i), {24'd0, p1_rdata}, {24'd0, vecs[i].rd1});
      chk($sformatf("v%0d_mem_we", i), {31'd0, mem_we}, {31'd0, vecs[i].mwe});
      chk($sformatf("v%0d_mem_addr", i), {20'd0, mem_addr}, {20'd0, vecs[i].maddr});
      chk($sformatf("v%0d_mem_wdata", i), {24'd0, mem_wdata}, {24'd0, vecs[i].mwd});
    end

    // contention from reset with MAX_BURST=4: p0 x4, p1 x4, p0 x4
    do_reset();
    ord = 12'b0000_1111_0000;
    exp_q = {};
    exp_q.push_back(18'h0);
    exp_q.push_back(18'h0);
    for (int k = 0; k < 14; k++) begin
      if (k < 12) begin
        drive(1'b1, 1'b0, 12'h010, 8'h00, 1'b1, 1'b0, 12'h810, 8'h00);
        port = ord[k];
        exp_g = port ? 2'b10 : 2'b01;
        chk($sformatf("cont%0d_gnt", k), {30'd0, p1_gnt, p0_gnt}, {30'd0, exp_g});
        sb_cycle($sformatf("cont%0d_rsp", k), port ? {2'b10, 8'h96, 8'h00} : {2'b01, 8'h00, 8'h3C});
      end else begin
        idle();
        chk($sformatf("cont%0d_gnt", k), {30'd0, p1_gnt, p0_gnt}, 32'd0);
        sb_cycle($sformatf("cont%0d_rsp", k), 18'h0);
      end
    end

    // owner drop: p0 owns with burst_cnt=2, drops req, p1 takes over with burst_cnt=1
    do_reset();
    drive(1'b1, 1'b0, 12'h010, 8'h00, 1'b1, 1'b0, 12'h810, 8'h00);
    chk("drop_gnt0", {30'd0, p1_gnt, p0_gnt}, 32'd1);
    drive(1'b1, 1'b0, 12'h010, 8'h00, 1'b1, 1'b0, 12'h810, 8'h00);
    chk("drop_gnt1", {30'd0, p1_gnt, p0_gnt}, 32'd1);
    drive(1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 12'h810, 8'h00);
    chk("drop_state_before", {28'd0, dbg_owner, dbg_burst_cnt}, {28'd0, 1'b0, 3'd2});
    chk("drop_gnt2", {30'd0, p1_gnt, p0_gnt}, 32'd2);
    idle();
    chk("drop_state_after", {28'd0, dbg_owner, dbg_burst_cnt}, {28'd0, 1'b1, 3'd1});

    // idle cycle clears the burst count: p0 x3, idle, then p0 x4 before p1
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 12'h010, 8'h00, 1'b0, 1'b0, 12'h000, 8'h00);
      chk($sformatf("idle_pre%0d_gnt", k), {30'd0, p1_gnt, p0_gnt}, 32'd1);
    end
    idle();
    chk("idle_cnt3", {29'd0, dbg_burst_cnt}, 32'd3);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 12'h010, 8'h00, 1'b1, 1'b0, 12'h810, 8'h00);
      if (k == 0) chk("idle_cnt0", {29'd0, dbg_burst_cnt}, 32'd0);
      chk($sformatf("idle_post%0d_gnt", k), {30'd0, p1_gnt, p0_gnt}, (k < 4) ? 32'd1 : 32'd2);
    end

    // reset mid-stream: two reads in flight are discarded
    do_reset();
    drive(1'b1, 1'b0, 12'h005, 8'h00, 1'b0, 1'b0, 12'h000, 8'h00);
    chk("mid_gnt0", {30'd0, p1_gnt, p0_gnt}, 32'd1);
    drive(1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 12'h7FF, 8'h00);
    chk("mid_gnt1", {30'd0, p1_gnt, p0_gnt}, 32'd2);
    @(negedge clk);
    rst_n = 1'b0;
    p0_req = 1'b1; p1_req = 1'b1;
    #1;
    chk("mid_rst_gnt",    {30'd0, p1_gnt, p0_gnt}, 32'd0);
    chk("mid_rst_rvalid", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
    chk("mid_rst_rdata",  {16'd0, p1_rdata, p0_rdata}, 32'd0);
    chk("mid_rst_mem",    {11'd0, mem_we, mem_addr, mem_wdata}, 32'd0);
    @(negedge clk);
    p0_req = 1'b0; p1_req = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      idle();
      chk($sformatf("mid_post%0d_rvalid", k), {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
    end
    drive(1'b1, 1'b0, 12'h005, 8'h00, 1'b1, 1'b0, 12'h7FF, 8'h00);
    chk("mid_first_contest", {30'd0, p1_gnt, p0_gnt}, 32'd1);
    idle();

    // MAX_BURST=1 instance: strict alternation starting with p0
    do_reset();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      a0_req = (k < 8); a0_addr = 12'h005;
      a1_req = (k < 8); a1_addr = 12'h7FF;
      #1;
      if (k < 8) begin
        exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
        chk($sformatf("alt%0d_gnt", k), {30'd0, a1_gnt, a0_gnt}, {30'd0, exp_g});
      end
      if (k >= 2) begin
        if ((k - 2) % 2 == 0) begin
          chk($sformatf("alt%0d_rsp", k), {14'd0, a1_rvalid, a0_rvalid, a1_rdata, a0_rdata}, {14'd0, 2'b01, 8'h00, 8'hA5});
        end else begin
          chk($sformatf("alt%0d_rsp", k), {14'd0, a1_rvalid, a0_rvalid, a1_rdata, a0_rdata}, {14'd0, 2'b10, 8'h5A, 8'h00});
        end
      end else begin
        chk($sformatf("alt%0d_rsp", k), {30'd0, a1_rvalid, a0_rvalid}, 32'd0);
      end
    end

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
